// File: rtl/rtc_driver.sv
// 24-hour HH:MM:SS real-time clock driving six active-low 7-segment digits.
// A 1 Hz tick advances time in run mode. In manual mode time is frozen and
// three debounced keys step the hour, minute and second fields independently.
module rtc_driver #(
   parameter int CLK_HZ = 50_000_000,
   parameter int DB_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       man_sw,
   input  logic [2:0] push_but,
   output logic [6:0] sev_seg [5:0]
);

   localparam int W1HZ = $clog2(CLK_HZ);
   localparam int W1K  = $clog2(CLK_HZ / 1000 + 1);

   // increment a two-digit BCD field 00..59 with wrap
   function automatic logic [7:0] inc_mod60(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd5) begin
            r = 8'h00;
         end else begin
            r = {v[7:4] + 4'd1, 4'd0};
         end
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // increment a two-digit BCD field 00..23 with wrap
   function automatic logic [7:0] inc_mod24(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h23) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal codes are blank
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // dividers
   logic [W1HZ-1:0] cnt1Hz, cnt1Hz_d, div1Hz;
   logic [W1K-1:0]  cnt1kHz, cnt1kHz_d, div1kHz;
   logic            cnten, shiften;

   // debounce: raw active-low key samples, so all-ones means released
   logic [DB_LEN-1:0] db_sr   [2:0];
   logic [DB_LEN-1:0] db_sr_d [2:0];
   logic [2:0]        key_dn, key_dn_d;
   logic [2:0]        setpben, setpben_d;

   // time digits
   logic [3:0] sec0, sec1, min0, min1, hr0, hr1;
   logic [7:0] sec_n, min_n, hr_n;

   assign div1Hz  = W1HZ'(CLK_HZ - 1);
   assign div1kHz = W1K'(CLK_HZ / 1000 - 1);

   // tick strobes and next divider counts; 1 Hz divider parks at zero while paused
   always_comb begin
      cnten   = 1'b0;
      shiften = (cnt1kHz == div1kHz);
      if (man_sw) begin
         cnt1Hz_d = '0;
      end else if (cnt1Hz == div1Hz) begin
         cnten    = 1'b1;
         cnt1Hz_d = '0;
      end else begin
         cnt1Hz_d = cnt1Hz + W1HZ'(1);
      end
      if (shiften) begin
         cnt1kHz_d = '0;
      end else begin
         cnt1kHz_d = cnt1kHz + W1K'(1);
      end
   end

   // key sampling, pressed/released hysteresis and rising-edge press pulse
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         if (shiften) begin
            db_sr_d[i] = {db_sr[i][DB_LEN-2:0], push_but[i]};
         end else begin
            db_sr_d[i] = db_sr[i];
         end
         if (db_sr[i] == '0) begin
            key_dn_d[i] = 1'b1;
         end else if (db_sr[i] == '1) begin
            key_dn_d[i] = 1'b0;
         end else begin
            key_dn_d[i] = key_dn[i];
         end
         setpben_d[i] = key_dn_d[i] & ~key_dn[i];
      end
   end

   // next time value: full carry chain on a tick, independent fields in manual set
   always_comb begin
      sec_n = {sec1, sec0};
      min_n = {min1, min0};
      hr_n  = {hr1, hr0};
      if (cnten) begin
         sec_n = inc_mod60({sec1, sec0});
         if ({sec1, sec0} == 8'h59) begin
            min_n = inc_mod60({min1, min0});
            if ({min1, min0} == 8'h59) begin
               hr_n = inc_mod24({hr1, hr0});
            end else begin
               hr_n = {hr1, hr0};
            end
         end else begin
            min_n = {min1, min0};
         end
      end else if (man_sw) begin
         if (setpben[0]) begin
            sec_n = inc_mod60({sec1, sec0});
         end else begin
            sec_n = {sec1, sec0};
         end
         if (setpben[1]) begin
            min_n = inc_mod60({min1, min0});
         end else begin
            min_n = {min1, min0};
         end
         if (setpben[2]) begin
            hr_n = inc_mod24({hr1, hr0});
         end else begin
            hr_n = {hr1, hr0};
         end
      end else begin
         sec_n = {sec1, sec0};
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt1Hz  <= '0;
         cnt1kHz <= '0;
         for (int i = 0; i < 3; i++) begin
            db_sr[i] <= '1;
         end
         key_dn  <= 3'b000;
         setpben <= 3'b000;
         sec0    <= 4'd0;
         sec1    <= 4'd0;
         min0    <= 4'd0;
         min1    <= 4'd0;
         hr0     <= 4'd0;
         hr1     <= 4'd0;
      end else begin
         cnt1Hz  <= cnt1Hz_d;
         cnt1kHz <= cnt1kHz_d;
         for (int i = 0; i < 3; i++) begin
            db_sr[i] <= db_sr_d[i];
         end
         key_dn  <= key_dn_d;
         setpben <= setpben_d;
         sec0    <= sec_n[3:0];
         sec1    <= sec_n[7:4];
         min0    <= min_n[3:0];
         min1    <= min_n[7:4];
         hr0     <= hr_n[3:0];
         hr1     <= hr_n[7:4];
      end
   end

   // display decode straight from the digit registers
   always_comb begin
      sev_seg[0] = seg7(sec0);
      sev_seg[1] = seg7(sec1);
      sev_seg[2] = seg7(min0);
      sev_seg[3] = seg7(min1);
      sev_seg[4] = seg7(hr0);
      sev_seg[5] = seg7(hr1);
   end

endmodule

// File: tb/tb_rtc_driver.sv
// Scoreboard bench for rtc_driver, built with a small CLK_HZ so ticks are short.
module tb_rtc_driver;

   localparam int CLK_HZ = 2000;
   localparam int DB_LEN = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       man_sw;
   logic [2:0] push_but;
   logic [6:0] sev_seg [5:0];

   int total = 0;
   int bad   = 0;
   int mh = 0, mm = 0, ms = 0;
   int pulse0 = 0;
   logic [23:0] sb_q [$];
   logic [41:0] disp_obs;
   logic [23:0] digits_obs;

   always #5 clk = ~clk;

   rtc_driver #(.CLK_HZ(CLK_HZ), .DB_LEN(DB_LEN)) dut (
      .clk      (clk),
      .rst      (rst),
      .man_sw   (man_sw),
      .push_but (push_but),
      .sev_seg  (sev_seg)
   );

   assign disp_obs   = {sev_seg[5], sev_seg[4], sev_seg[3], sev_seg[2], sev_seg[1], sev_seg[0]};
   assign digits_obs = {dut.hr1, dut.hr0, dut.min1, dut.min0, dut.sec1, dut.sec0};

   // count seconds-key press pulses
   always @(posedge clk) begin
      if (rst) pulse0 <= 0;
      else if (dut.setpben[0]) pulse0 <= pulse0 + 1;
   end

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
         4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
         4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [41:0] disp_of(input logic [23:0] t);
      return {glyph(t[23:20]), glyph(t[19:16]), glyph(t[15:12]),
              glyph(t[11:8]), glyph(t[7:4]), glyph(t[3:0])};
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_front(input string tag);
      logic [23:0] e;
      chk({tag, "_sbq"}, 48'(sb_q.size()), 48'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, "_disp"}, 48'(disp_obs), 48'(disp_of(e)));
         chk({tag, "_dig"}, 48'(digits_obs), 48'(e));
      end
   endtask

   // press the keys in mask (1 = pressed) long enough to debounce, then release
   task automatic press(input logic [2:0] mask);
      if (man_sw) begin
         if (mask[0]) ms = (ms + 1) % 60;
         if (mask[1]) mm = (mm + 1) % 60;
         if (mask[2]) mh = (mh + 1) % 24;
      end
      sb_q.push_back(to_bcd(mh, mm, ms));
      push_but = ~mask;
      repeat (16) @(negedge clk);
      push_but = 3'b111;
      repeat (16) @(negedge clk);
      compare_front("press");
   endtask

   // wait for the next displayed change and check both the new time and the period
   task automatic wait_tick(input bit mash);
      int n;
      logic [41:0] start;
      ms++;
      if (ms == 60) begin
         ms = 0;
         mm++;
         if (mm == 60) begin
            mm = 0;
            mh = (mh + 1) % 24;
         end
      end
      sb_q.push_back(to_bcd(mh, mm, ms));
      start = disp_obs;
      n = 0;
      while (disp_obs == start && n < 3 * CLK_HZ) begin
         @(negedge clk);
         n++;
         if (mash && n == 10) push_but = 3'b000;
         if (mash && n == 23) push_but = 3'b111;
      end
      chk("tick_period", 48'(n), 48'(CLK_HZ));
      compare_front("tick");
   endtask

   initial begin
      int p0;
      rst      = 1'b1;
      man_sw   = 1'b1;
      push_but = 3'b111;
      repeat (2) @(negedge clk);
      sb_q.push_back(to_bcd(0, 0, 0));
      compare_front("reset");
      for (int i = 0; i < 6; i++) chk("reset_seg", 48'(sev_seg[i]), 48'h40);
      chk("reset_cnt1Hz", 48'(dut.cnt1Hz), 48'd0);
      rst = 1'b0;
      @(negedge clk);

      // manual preset to 23:59:59
      repeat (23) press(3'b100);
      repeat (59) press(3'b010);
      repeat (59) press(3'b001);
      chk("man_cnt_hold", 48'(dut.cnt1Hz), 48'd0);
      chk("man_cnten", 48'(dut.cnten), 48'd0);

      // full rollover on the first tick, one full period after leaving manual
      man_sw = 1'b0;
      wait_tick(1'b0);
      chk("rollover", 48'(digits_obs), 48'h000000);

      // keys ignored in run mode while counting continues
      p0 = pulse0;
      wait_tick(1'b1);
      chk("run_key_pulse", 48'(pulse0 - p0), 48'd1);
      wait_tick(1'b0);

      // preset 20:57:59 and check the minute carry
      man_sw = 1'b1;
      @(negedge clk);
      repeat (20) press(3'b100);
      repeat (57) press(3'b010);
      repeat (57) press(3'b001);
      man_sw = 1'b0;
      wait_tick(1'b0);
      chk("min_carry", 48'(digits_obs), 48'h205800);
      wait_tick(1'b0);

      // preset 22:58:58 then 20 simultaneous pulses on all three fields
      man_sw = 1'b1;
      @(negedge clk);
      repeat (2) press(3'b100);
      repeat (57) press(3'b001);
      chk("preset_225858", 48'(digits_obs), 48'h225858);
      repeat (20) press(3'b111);
      chk("triple_181818", 48'(digits_obs), 48'h181818);

      // short bounces never qualify; a stable press gives exactly one pulse
      p0 = pulse0;
      repeat (5) begin
         push_but = 3'b110;
         repeat (5) @(negedge clk);
         push_but = 3'b111;
         repeat (3) @(negedge clk);
      end
      repeat (16) @(negedge clk);
      chk("bounce_pulses", 48'(pulse0 - p0), 48'd0);
      sb_q.push_back(to_bcd(mh, mm, ms));
      compare_front("bounce");
      press(3'b001);
      chk("stable_pulses", 48'(pulse0 - p0), 48'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
